// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types, constants and the anode one-hot helper for the display mux
package disp_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_BLANK  = 8'hFF;
    localparam int   MAX_DIGITS = 16;

    // Returns a MAX_DIGITS-wide one-hot; callers truncate to their digit count.
    function automatic logic [MAX_DIGITS-1:0] onehot_n(input logic [3:0] idx);
        return MAX_DIGITS'(1) << idx;
    endfunction

endpackage

// File: rtl/refresh_timer.sv
// rtl/refresh_timer.sv - slot counter and digit scan; exposes next-state values so outputs register in step
module refresh_timer #(
    parameter int N_DIGITS    = 8,
    parameter int SLOT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [$clog2(N_DIGITS)-1:0]   digit_idx,
    output logic [$clog2(N_DIGITS)-1:0]   idx_nxt,
    output logic [$clog2(SLOT_CYCLES)-1:0] cnt_nxt,
    output logic                          slot_start,
    output logic                          frame_tick
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam int IDX_W = $clog2(N_DIGITS);

    logic [CNT_W-1:0] slot_cnt;

    // slot_start is high in the cycle whose closing edge begins the next slot.
    always_comb begin
        slot_start = (slot_cnt == CNT_W'(SLOT_CYCLES - 1));
        cnt_nxt    = slot_start ? '0 : slot_cnt + CNT_W'(1);
        idx_nxt    = digit_idx;
        if (slot_start) begin
            if (digit_idx == IDX_W'(N_DIGITS - 1)) begin
                idx_nxt = '0;
            end else begin
                idx_nxt = digit_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cnt   <= '0;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            slot_cnt   <= cnt_nxt;
            digit_idx  <= idx_nxt;
            frame_tick <= slot_start && (idx_nxt == '0);
        end
    end

endmodule

// File: rtl/disp_mux_pwm.sv
// rtl/disp_mux_pwm.sv - N-digit 7-segment mux with blanking, PWM dimming, enable mask and slot-coherent latching
module disp_mux_pwm
    import disp_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BRIGHT_W     = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_DIGITS*8-1:0]       in,
    input  logic [N_DIGITS-1:0]         en,
    input  logic [BRIGHT_W-1:0]         brightness,
    output logic [N_DIGITS-1:0]         an,
    output logic [7:0]                  sseg,
    output logic [$clog2(N_DIGITS)-1:0] digit_idx,
    output logic                        frame_tick
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam int IDX_W = $clog2(N_DIGITS);

    logic [IDX_W-1:0]    idx_nxt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                slot_start;

    logic                en_q, en_n;
    logic [BRIGHT_W-1:0] bright_q, bright_n;
    logic [BRIGHT_W-1:0] pwm_cnt, pwm_n;
    logic                drive_n;
    logic [N_DIGITS-1:0] an_n;

    refresh_timer #(
        .N_DIGITS    (N_DIGITS),
        .SLOT_CYCLES (SLOT_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .digit_idx  (digit_idx),
        .idx_nxt    (idx_nxt),
        .cnt_nxt    (cnt_nxt),
        .slot_start (slot_start),
        .frame_tick (frame_tick)
    );

    // Anode decision is made on next-state values so an and sseg always describe the same digit.
    always_comb begin
        pwm_n    = pwm_cnt + BRIGHT_W'(1);
        en_n     = slot_start ? en[idx_nxt] : en_q;
        bright_n = slot_start ? brightness : bright_q;
        drive_n  = (bright_n == '1) || (pwm_n < bright_n);
        an_n     = '1;
        if ((cnt_nxt >= CNT_W'(BLANK_CYCLES)) && en_n && drive_n) begin
            an_n = ~N_DIGITS'(onehot_n(4'(idx_nxt)));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an       <= '1;
            sseg     <= SEG_BLANK;
            en_q     <= 1'b0;
            bright_q <= '0;
            pwm_cnt  <= '0;
        end else begin
            an       <= an_n;
            en_q     <= en_n;
            bright_q <= bright_n;
            pwm_cnt  <= pwm_n;
            if (slot_start) begin
                sseg <= in[{idx_nxt, 3'b000} +: 8];
            end
        end
    end

endmodule

// File: tb/tb_disp_mux_pwm.sv
// tb/tb_disp_mux_pwm.sv - directed self-checking bench for disp_mux_pwm (4 digits, 8-cycle slots, 2-cycle blank)
module tb_disp_mux_pwm;

    localparam int N  = 4;
    localparam int SC = 8;
    localparam int BC = 2;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in_r  = 32'h0F_F0_55_AA;
    logic [3:0]  en_r  = 4'hF;
    logic [1:0]  br_r  = 2'd3;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] m_seg;
    logic       m_en;
    logic [1:0] m_b;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic [1:0] exp_idx;
    logic       exp_tick;

    disp_mux_pwm #(
        .N_DIGITS     (N),
        .SLOT_CYCLES  (SC),
        .BLANK_CYCLES (BC),
        .BRIGHT_W     (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in_r),
        .en         (en_r),
        .brightness (br_r),
        .an         (an),
        .sseg       (sseg),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Expected outputs for cycle t after reset release; latches mirror inputs seen at each slot boundary.
    task automatic model_step(input int t);
        int d, c;
        logic [3:0] oh;
        d = (t / SC) % N;
        c = t % SC;
        if (c == 0 && t > 0) begin
            m_seg = in_r[8*d +: 8];
            m_en  = en_r[d];
            m_b   = br_r;
        end
        oh       = 4'b0001 << d;
        exp_an   = (c >= BC && m_en && (m_b == 2'd3 || (t % 4) < int'(m_b))) ? ~oh : 4'hF;
        exp_seg  = m_seg;
        exp_idx  = 2'(d);
        exp_tick = (c == 0 && d == 0 && t > 0);
    endtask

    task automatic release_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_seg = 8'hFF;
        m_en  = 1'b0;
        m_b   = 2'd0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (an !== 4'hF || sseg !== 8'hFF || frame_tick !== 1'b0 || digit_idx !== 2'd0) begin
                miscompares++;
                $display("FAIL reset cyc%0d: an=%h sseg=%h tick=%b idx=%0d, want an=f sseg=ff tick=0 idx=0",
                         i, an, sseg, frame_tick, digit_idx);
            end
        end
    endtask

    task automatic test_scan();
        int ticks;
        in_r = 32'h0F_F0_55_AA; en_r = 4'hF; br_r = 2'd3;
        release_reset();
        ticks = 0;
        for (int t = 0; t < 80; t++) begin
            model_step(t);
            vectors++;
            if (an !== exp_an || sseg !== exp_seg || digit_idx !== exp_idx) begin
                miscompares++;
                $display("FAIL scan t=%0d: an=%h sseg=%h idx=%0d, want an=%h sseg=%h idx=%0d",
                         t, an, sseg, digit_idx, exp_an, exp_seg, exp_idx);
            end
            vectors++;
            if (frame_tick !== exp_tick) begin
                miscompares++;
                $display("FAIL frame_tick t=%0d: got %b want %b", t, frame_tick, exp_tick);
            end
            if (frame_tick === 1'b1) ticks++;
            @(negedge clk);
            #1;
        end
        vectors++;
        if (ticks != 2) begin
            miscompares++;
            $display("FAIL tick_count: got %0d want 2", ticks);
        end
    endtask

    task automatic test_tearing();
        in_r = 32'h0F_F0_55_AA; en_r = 4'hF; br_r = 2'd3;
        release_reset();
        for (int t = 0; t < 48; t++) begin
            model_step(t);
            vectors++;
            if (sseg !== exp_seg || an !== exp_an) begin
                miscompares++;
                $display("FAIL tearing t=%0d: sseg=%h an=%h, want sseg=%h an=%h", t, sseg, an, exp_seg, exp_an);
            end
            if (t == 15 || t == 40) begin
                vectors++;
                if (sseg !== ((t == 15) ? 8'h55 : 8'h3C)) begin
                    miscompares++;
                    $display("FAIL tearing_fixed t=%0d: sseg=%h want %h", t, sseg, (t == 15) ? 8'h55 : 8'h3C);
                end
            end
            if (t == 12) in_r[15:8] = 8'h3C;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_pwm(input logic [1:0] level);
        int lows;
        in_r = 32'h0F_F0_55_AA; en_r = 4'hF; br_r = level;
        release_reset();
        lows = 0;
        for (int t = 0; t < 48; t++) begin
            model_step(t);
            vectors++;
            if (an !== exp_an || frame_tick !== exp_tick) begin
                miscompares++;
                $display("FAIL pwm%0d t=%0d: an=%h tick=%b, want an=%h tick=%b",
                         level, t, an, frame_tick, exp_an, exp_tick);
            end
            if (an !== 4'hF) lows++;
            @(negedge clk);
            #1;
        end
        // Slots 1..5 each have exactly one active cycle at level 1 (slot offset 4), none at level 0.
        vectors++;
        if (lows != ((level == 2'd1) ? 5 : 0)) begin
            miscompares++;
            $display("FAIL pwm%0d_lowcount: got %0d want %0d", level, lows, (level == 2'd1) ? 5 : 0);
        end
    endtask

    task automatic test_enable_mask();
        in_r = 32'h0F_F0_55_AA; en_r = 4'b1010; br_r = 2'd3;
        release_reset();
        for (int t = 0; t < 48; t++) begin
            model_step(t);
            vectors++;
            if (an !== exp_an || an[0] !== 1'b1 || an[2] !== 1'b1) begin
                miscompares++;
                $display("FAIL enable t=%0d: an=%h want %h", t, an, exp_an);
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_async_reset();
        in_r = 32'h0F_F0_55_AA; en_r = 4'hF; br_r = 2'd3;
        release_reset();
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            #1;
        end
        vectors++;
        if (an !== 4'hB || sseg !== 8'hF0 || digit_idx !== 2'd2) begin
            miscompares++;
            $display("FAIL async_pre: an=%h sseg=%h idx=%0d, want an=b sseg=f0 idx=2", an, sseg, digit_idx);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (an !== 4'hF || sseg !== 8'hFF || digit_idx !== 2'd0 || frame_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL async_now: an=%h sseg=%h idx=%0d tick=%b, want an=f sseg=ff idx=0 tick=0",
                     an, sseg, digit_idx, frame_tick);
        end
        release_reset();
        for (int t = 0; t < 20; t++) begin
            model_step(t);
            vectors++;
            if (an !== exp_an || sseg !== exp_seg || digit_idx !== exp_idx) begin
                miscompares++;
                $display("FAIL async_restart t=%0d: an=%h sseg=%h idx=%0d, want an=%h sseg=%h idx=%0d",
                         t, an, sseg, digit_idx, exp_an, exp_seg, exp_idx);
            end
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tearing();
        test_pwm(2'd1);
        test_pwm(2'd0);
        test_enable_mask();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/disp_mux_pwm.md
Name: disp_mux_pwm

Overview:
- Parametrised N-digit 7-segment time-multiplexing driver. Successor to the fixed 4-digit display mux.
- Adds the following over the 4-digit mux:
  - configurable digit count and slot length
  - an inter-digit blanking interval (anti-ghosting)
  - PWM brightness control
  - a per-digit enable mask
  - frame-coherent input latching
- Sits between board-level display logic (counters, hex decoders) and the active-low anode/segment pins.

Parameters:
- N_DIGITS, 8, number of digits/anodes (2..16).
- SLOT_CYCLES, 50000, clk cycles each digit is selected (>= BLANK_CYCLES+2).
- BLANK_CYCLES, 500, cycles at the start of every slot with all anodes off (>= 1).
- BRIGHT_W, 4, width of brightness control.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in  input  N_DIGITS*8  segment patterns, active-low. Digit d = in[8d+7:8d]; bit 7 = DP.
- en  input  N_DIGITS  per-digit enable; 0 keeps that anode off for its whole slot.
- brightness  input  BRIGHT_W  duty level; 0 = dark, all-ones = 100%.
- an  output  N_DIGITS  anode selects, active-low, registered.
- sseg  output  8  segment drive, active-low, registered.
- digit_idx  output  $clog2(N_DIGITS)  index of the digit owning the current slot.
- frame_tick  output  1  one-cycle pulse on the first cycle of digit 0's slot.

Behaviour:
- Reset (reset=0, async) values:
  - slot_cnt=0, digit_idx=0, pwm_cnt=0
  - an='1 (all off), sseg=8'hFF, frame_tick=0
  - latched segment/brightness/enable registers = blank/0
- First post-reset slot is digit 0 with latched data = blank. Real data appears from the second slot onward.
- Slot timer:
  - slot_cnt counts 0..SLOT_CYCLES-1, then wraps to 0.
  - On wrap, digit_idx advances d -> d+1, and N_DIGITS-1 -> 0.
  - Non-power-of-two N_DIGITS wraps correctly; no unused index is ever visited.
- Slot latching, on the edge that starts a slot for digit k (slot_cnt becomes 0):
  - sseg <= in[k]
  - bright_q <= brightness
  - en_q <= en[k]
  - Inputs changing mid-slot have no effect until the next slot boundary (no tearing).
- frame_tick = 1 exactly for the cycle where digit_idx=0 and slot_cnt=0.
- PWM:
  - pwm_cnt is BRIGHT_W bits, free-running, +1 every cycle, wraps.
  - drive = (bright_q == all-ones) || (pwm_cnt < bright_q).
- Anode logic:
  - an is registered on the same edge as sseg, so an and sseg never disagree about the digit in any cycle.
  - an = ~(onehot(digit_idx)) when slot_cnt >= BLANK_CYCLES && en_q && drive; otherwise an = '1.
  - The edge that starts a slot always drives an='1.
- Exactly one anode or none low in any cycle.
- Latency: a slot begins -> an for that digit first low BLANK_CYCLES cycles later (brightness=max, en=1).
- Reset mid-slot: outputs go to their reset values immediately (async). On release, the scan restarts from digit 0, slot_cnt=0.
- Brightness = 0: an stays '1 permanently; the scan still runs and frame_tick still pulses.

Decomposition:
- Package disp_pkg:
  - SEG_BLANK = 8'hFF
  - function onehot_n(idx) returning an N-bit one-hot
  - typedef seg_t = logic [7:0]
- One natural sub-module, refresh_timer:
  - owns slot_cnt, digit_idx, the slot_start strobe and frame_tick
  - parameters N_DIGITS and SLOT_CYCLES
- The top level holds the latch registers, PWM and output registers.

Test Plan (N_DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2, BRIGHT_W=2):
- Reset/scan:
  - Stimulus: hold reset=0 for 5 cycles, then release; in=32'h0F_F0_55_AA, en=4'hF, brightness=3.
  - Response: an=4'hF during reset. Slot sequence is digit 0,1,2,3,0. In each slot, an=~onehot for cycles 2..7 only. sseg=AA/55/F0/0F from the second frame.
- Frame tick: same stimulus -> frame_tick pulses exactly once every 32 cycles, coincident with digit_idx=0 and slot_cnt=0.
- Tearing: change in[15:8] from 55 to 3C at slot_cnt=4 of digit 1 -> sseg holds 55 until digit 1's next slot, which shows 3C.
- PWM:
  - brightness=1 -> during the active part of a slot, an low only when pwm_cnt==0 (1 of 4 cycles).
  - brightness=0 -> an=4'hF always.
- Enable mask: en=4'b1010 -> digits 0 and 2 never drive an low; digits 1 and 3 behave normally.
- Async reset: assert reset=0 mid-slot of digit 2 -> an=4'hF and sseg=FF in the same cycle, without waiting for a clock. After release, scan restarts at digit 0 with slot_cnt=0.
